// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: blank code, hex segment table
// and the scan FSM state type.
package ssd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n, dp off.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble][6:0];
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_seg7_decode.sv
// Combinational hex nibble to active-low g..a segment pattern; one instance serves every
// digit because only the lit digit is ever decoded.
module seg7_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Scan controller for a common-anode seven-segment bank. New words are staged in a pending
// register and swapped into the display register only at the frame wrap.
//   state | meaning
//   GUARD | all anodes off, segments blank, between digit slots
//   ON    | anode of digit idx driven, decoded segments of that digit
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_suppress,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int TMAX = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    wrap;

  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    tail_zero;
  logic [3:0]              nibble_cur;
  logic [6:0]              seg7;
  logic                    accept;
  logic                    commit;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      GUARD: begin
        if (timer_q == GUARD_LAST) begin
          state_d = ON;
          timer_d = '0;
        end
      end
      ON: begin
        if (timer_q == ON_LAST) begin
          state_d = GUARD;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = GUARD;
        timer_d = '0;
      end
    endcase
  end

  // accept and commit are exclusive: one needs pend_q low, the other high,
  // so a word accepted in the wrap cycle always waits for the next frame.
  assign accept = load_valid & ~pend_q;
  assign commit = wrap & pend_q;

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (commit) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_d      = 1'b0;
    end else if (accept) begin
      pend_d      = 1'b1;
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
    end
  end

  // Digit i is blank when it and every more significant nibble are zero and its dp is off.
  always_comb begin
    tail_zero = 1'b1;
    lz_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      tail_zero   = tail_zero & (disp_data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_suppress & tail_zero & ~disp_dp_q[i];
    end
  end

  assign nibble_cur = disp_data_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble_cur),
    .seg_o    (seg7)
  );

  always_comb begin
    seg_d  = SEG_BLANK;
    an_d   = '1;
    tick_d = wrap;
    if (state_q == ON) begin
      an_d[idx_q] = 1'b0;
      if (!lz_blank[idx_q]) begin
        seg_d = {~disp_dp_q[idx_q], seg7};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GUARD;
      timer_q     <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

  assign load_ready = ~pend_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
